// File: rtl/result_packer_pkg.sv
// rtl/result_packer_pkg.sv - shared types and helpers for the result packer
package result_packer_pkg;

    typedef enum logic [0:0] {EMPTY = 1'b0, PARTIAL = 1'b1} state_t;

    // Wide enough to hold a lane count of up to 32 (index plus one past the end)
    localparam int LANE_IDX_W = 6;

    function automatic logic [31:0] keep_mask(input logic [LANE_IDX_W-1:0] idx, input int lanes);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < int'(idx)) && (i < lanes);
        end
        return m;
    endfunction

endpackage

// File: rtl/result_packer_if.sv
// rtl/result_packer_if.sv - sample input stream and packed word output handshake
interface result_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic [DATA_WIDTH*LANES-1:0] out_data;
    logic [LANES-1:0]            out_keep;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_keep, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_keep, out_valid
    );
endinterface

// File: rtl/result_packer_fifo.sv
// rtl/result_packer_fifo.sv - show-ahead word FIFO; push while full is legal when a pop happens
module packer_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/result_packer.sv
// rtl/result_packer.sv - packs LANES samples per word into a FIFO; optional idle auto-flush via PACKER_TIMEOUT_EN
module result_packer
    import result_packer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    result_packer_if.slave         bus,
    input  logic                   flush,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [COUNT_WIDTH-1:0] drop_count
);
    localparam int WW = DATA_WIDTH * LANES;
    localparam logic [0:0] ST_EMPTY   = EMPTY;
    localparam logic [0:0] ST_PARTIAL = PARTIAL;

    logic [0:0]            state;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic [LANE_IDX_W-1:0] cnt_after;
    logic [WW-1:0]         held;
    logic [WW-1:0]         word_with;
    logic [LANES-1:0]      push_keep;
    logic                  timeout_fire;
    logic                  do_flush;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  accepted;
    logic                  dropped;

    // Lanes beyond lane_idx are always zero in held, so a partial word needs no masking
    always_comb begin
        word_with = held;
        if (bus.in_valid) begin
            word_with[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
        end
    end

    assign cnt_after = lane_idx + LANE_IDX_W'(bus.in_valid);
    assign do_flush  = flush || timeout_fire;
    assign push      = (bus.in_valid && lane_idx == LANE_IDX_W'(LANES-1))
                    || (do_flush && (state == ST_PARTIAL || bus.in_valid));
    assign push_keep = LANES'(keep_mask(cnt_after, LANES));
    assign pop       = bus.out_valid && bus.out_ready;
    assign accepted  = push && (!full || pop);
    assign dropped   = push && full && !pop;

    packer_fifo #(
        .WIDTH (WW + LANES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_keep, word_with}),
        .pop       (pop),
        .pop_data  ({bus.out_keep, bus.out_data}),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid = !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            lane_idx <= '0;
            held     <= '0;
        end else if (push) begin
            state    <= ST_EMPTY;
            lane_idx <= '0;
            held     <= '0;
        end else if (bus.in_valid) begin
            state    <= ST_PARTIAL;
            lane_idx <= cnt_after;
            held     <= word_with;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            word_count <= '0;
            drop_count <= '0;
        end else begin
            if (accepted) word_count <= word_count + 1'b1;
            if (dropped)  drop_count <= drop_count + 1'b1;
            if (dropped)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_fire = (state == ST_PARTIAL) && !bus.in_valid
                       && (idle_cnt == IDLE_W'(TIMEOUT-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_PARTIAL || bus.in_valid || push) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif
endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - vector table, directed corner sequences and randomized model check for result_packer
module tb_result_packer;
    localparam int DW = 8;
    localparam int LN = 4;
    localparam int DEPTH = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic ovf_clr = 1'b0;
    logic overflow;
    logic [31:0] word_count;
    logic [31:0] drop_count;

    result_packer_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    result_packer #(
        .DATA_WIDTH(DW), .LANES(LN), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush), .overflow(overflow),
        .ovf_clr(ovf_clr), .word_count(word_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Reference model: pending samples, queued words {keep, data}, counters
    logic [7:0]  m_pend[$];
    logic [35:0] m_q[$];
    int unsigned m_wc, m_dc;
    logic        m_ovf;
    int          m_idle;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_clear();
        m_pend.delete();
        m_q.delete();
        m_wc = 0;
        m_dc = 0;
        m_ovf = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic fl,
                              input logic rdy, input logic clr);
        logic pop, fire, drop;
        logic [31:0] w;
        logic [3:0]  k;
        pop  = (m_q.size() > 0) && rdy;
        fire = 1'b0;
`ifdef PACKER_TIMEOUT_EN
        fire = !v && (m_pend.size() > 0) && (m_idle == TO-1);
`endif
        drop = 1'b0;
        if (v) m_pend.push_back(d);
        if (pop) void'(m_q.pop_front());
        if (m_pend.size() == LN || ((fl || fire) && m_pend.size() > 0)) begin
            w = 32'h0;
            for (int i = 0; i < m_pend.size(); i++) w[i*8 +: 8] = m_pend[i];
            k = 4'((1 << m_pend.size()) - 1);
            if (m_q.size() < DEPTH) begin
                m_q.push_back({k, w});
                m_wc++;
            end else begin
                m_dc++;
                drop = 1'b1;
            end
            m_pend.delete();
            m_idle = 0;
        end else if (v) begin
            m_idle = 0;
        end else if (m_pend.size() > 0) begin
            m_idle++;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic fl,
                         input logic rdy, input logic clr);
        bus.in_valid = v;
        bus.in_data = d;
        flush = fl;
        bus.out_ready = rdy;
        ovf_clr = clr;
        model_step(v, d, fl, rdy, clr);
        @(posedge clk);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_data", 64'(bus.out_data), 64'(m_q[0][31:0]));
            check("out_keep", 64'(bus.out_keep), 64'(m_q[0][35:32]));
        end
        check("word_count", 64'(word_count), 64'(m_wc));
        check("drop_count", 64'(drop_count), 64'(m_dc));
        check("overflow", 64'(overflow), 64'(m_ovf));
        bus.in_valid = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_out_data", 64'(bus.out_data), 64'h0);
        check("rst_out_keep", 64'(bus.out_keep), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_word_count", 64'(word_count), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic [31:0] e_wc;
    } vec_t;

    vec_t vecs[17];
    logic [7:0] bv;

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 32'd1};
        vecs[4]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd1};
        vecs[5]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 32'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd2};
        vecs[13] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 32'd3};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd3};
        vecs[15] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 32'h00000005, 4'h1, 32'd4};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'd4};

        do_reset();
        foreach (vecs[i]) begin
            bus.in_valid = vecs[i].v;
            bus.in_data = vecs[i].d;
            flush = vecs[i].fl;
            bus.out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].e_data));
                check($sformatf("vec%0d_keep", i), 64'(bus.out_keep), 64'(vecs[i].e_keep));
            end
            check($sformatf("vec%0d_wc", i), 64'(word_count), 64'(vecs[i].e_wc));
            check($sformatf("vec%0d_dc", i), 64'(drop_count), 64'h0);
        end
        bus.in_valid = 1'b0;
        flush = 1'b0;

        // Overflow: 17 words into a stalled 16-deep buffer
        do_reset();
        bv = 8'h00;
        for (int i = 0; i < 17 * LN; i++) begin
            cycle(1'b1, bv, 1'b0, 1'b0, 1'b0);
            bv++;
        end
        check("ovf_wc", 64'(word_count), 64'd16);
        check("ovf_dc", 64'(drop_count), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("stall_head", 64'(bus.out_data), 64'h03020100);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 64'(overflow), 64'd0);
        // Word completes while full but a pop happens the same edge
        for (int i = 0; i < LN; i++) begin
            cycle(1'b1, bv, 1'b0, i == LN-1, 1'b0);
            bv++;
        end
        check("full_pop_dc", 64'(drop_count), 64'd1);
        check("full_pop_wc", 64'(word_count), 64'd17);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("drained", 64'(bus.out_valid), 64'd0);

        // Reset mid-word
        do_reset();
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 8'hDE, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hAD, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hBE, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        check("clean_data", 64'(bus.out_data), 64'hEFBEADDE);
        check("clean_keep", 64'(bus.out_keep), 64'hF);

        // Idle timeout
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (k == 63) check("to_before", 64'(bus.out_valid), 64'd0);
`ifdef PACKER_TIMEOUT_EN
            if (k == 64) begin
                check("to_valid", 64'(bus.out_valid), 64'd1);
                check("to_data", 64'(bus.out_data), 64'h0000005A);
                check("to_keep", 64'(bus.out_keep), 64'h1);
            end
`else
            if (k == 70) check("no_to", 64'(bus.out_valid), 64'd0);
`endif
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
